// File: rtl/lcd_pkg.sv
// Shared 7-segment definitions for the display encoder and the lcd_dec decoder.
// Segment order is {a,b,c,d,e,f,g}, with segment a in bit 6.
package lcd_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        EMPTY,
        HAVE_ONES,
        HAVE_TENS,
        FULL
    } state_t;

    // Returns {legal, bcd}. Blank and all unlisted patterns are illegal.
    function automatic logic [4:0] seg2bcd(input logic [6:0] code);
        logic [4:0] res;
        res = 5'b0_0000;
        case (code)
            SEG_0: res = 5'b1_0000;
            SEG_1: res = 5'b1_0001;
            SEG_2: res = 5'b1_0010;
            SEG_3: res = 5'b1_0011;
            SEG_4: res = 5'b1_0100;
            SEG_5: res = 5'b1_0101;
            SEG_6: res = 5'b1_0110;
            SEG_7: res = 5'b1_0111;
            SEG_8: res = 5'b1_1000;
            SEG_9: res = 5'b1_1001;
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lcd_seg_filter.sv
// Per-digit-position stability filter: fires once when STABLE_CNT consecutive samples match.
// Fire is combinational with the qualifying sample; clr restarts the count between pairs.
module lcd_seg_filter #(
    parameter int STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       smp,
    input  logic [6:0] code,
    output logic       fire
);

    localparam logic [3:0] TARGET = 4'(STABLE_CNT);

    logic [6:0] last_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_nxt;

    // Count saturates at TARGET so a long stable run fires only once.
    always_comb begin
        cnt_nxt = cnt_q;
        if (smp) begin
            if (code == last_q && cnt_q != 4'd0)
                cnt_nxt = (cnt_q == TARGET) ? cnt_q : cnt_q + 4'd1;
            else
                cnt_nxt = 4'd1;
        end
    end

    assign fire = smp && (cnt_nxt == TARGET) && (cnt_q != TARGET);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 7'd0;
            cnt_q  <= 4'd0;
        end else if (clr) begin
            last_q <= 7'd0;
            cnt_q  <= 4'd0;
        end else if (smp) begin
            last_q <= code;
            cnt_q  <= cnt_nxt;
        end
    end

endmodule

// File: rtl/lcd_dec.sv
// Decodes streamed 7-segment digits into a two-digit binary value (0-99); latency 1 cycle
// (STABLE_CNT samples + 1 with SEG_STABLE_FILTER_EN). seg_ready drops while a result waits.
module lcd_dec
    import lcd_pkg::*;
#(
    parameter int STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       seg_valid,
    output logic       seg_ready,
    input  logic       seg_digit,
    input  logic [6:0] seg_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] bin_out,
    output logic       err
);

    if (STABLE_CNT < 2 || STABLE_CNT > 15) begin : g_bad_cnt
        $error("lcd_dec: STABLE_CNT must be 2..15");
    end

    state_t     state_q;
    state_t     state_nxt;
    logic [3:0] ones_q;
    logic [3:0] tens_q;
    logic       err_nxt;
    logic       accept;
    logic       dig_vld;
    logic       dig_legal;
    logic [3:0] dig_bcd;
    logic       out_hs;

    assign accept    = seg_valid && seg_ready;
    assign out_hs    = out_valid && out_ready;
    assign seg_ready = (state_q != FULL);
    assign out_valid = (state_q == FULL);
    assign {dig_legal, dig_bcd} = seg2bcd(seg_code);

`ifdef SEG_STABLE_FILTER_EN
    logic fire_ones;
    logic fire_tens;

    lcd_seg_filter #(.STABLE_CNT(STABLE_CNT)) u_flt_ones (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (out_hs),
        .smp     (accept && !seg_digit),
        .code    (seg_code),
        .fire    (fire_ones)
    );

    lcd_seg_filter #(.STABLE_CNT(STABLE_CNT)) u_flt_tens (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (out_hs),
        .smp     (accept && seg_digit),
        .code    (seg_code),
        .fire    (fire_tens)
    );

    assign dig_vld = fire_ones || fire_tens;
`else
    assign dig_vld = accept;
`endif

    always_comb begin
        state_nxt = state_q;
        err_nxt   = 1'b0;
        case (state_q)
            EMPTY, HAVE_ONES, HAVE_TENS: begin
                if (dig_vld) begin
                    if (!dig_legal) begin
                        state_nxt = EMPTY;
                        err_nxt   = 1'b1;
                    end else if (seg_digit) begin
                        state_nxt = (state_q == HAVE_ONES) ? FULL : HAVE_TENS;
                    end else begin
                        state_nxt = (state_q == HAVE_TENS) ? FULL : HAVE_ONES;
                    end
                end
            end
            FULL: begin
                if (out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            err     <= 1'b0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
        end else begin
            state_q <= state_nxt;
            err     <= err_nxt;
            if (err_nxt || out_hs) begin
                ones_q <= 4'd0;
                tens_q <= 4'd0;
            end else if (dig_vld && dig_legal) begin
                if (seg_digit) tens_q <= dig_bcd;
                else           ones_q <= dig_bcd;
            end
        end
    end

    // 9*10+9 = 99 fits in 7 bits.
    assign bin_out = 7'(tens_q) * 7'd10 + 7'(ones_q);

endmodule

// File: tb/tb_lcd_dec.sv
// Directed self-checking bench for lcd_dec; default build exercises the unfiltered path,
// SEG_STABLE_FILTER_EN builds exercise the stability filter with STABLE_CNT = 3.
module tb_lcd_dec;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       seg_valid = 1'b0;
    logic       seg_ready;
    logic       seg_digit = 1'b0;
    logic [6:0] seg_code = 7'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [6:0] bin_out;
    logic       err;

    int errors = 0;
    int checks = 0;

    lcd_dec #(.STABLE_CNT(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .seg_digit (seg_digit),
        .seg_code  (seg_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at posedge+1; presents one sample for one cycle, returns at the next posedge+1.
    task automatic put(input logic d, input logic [6:0] c);
        seg_valid = 1'b1;
        seg_digit = d;
        seg_code  = c;
        @(posedge clk) #1;
        seg_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk) #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1 (run did not complete)");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_seg_ready", seg_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_bin_out",   bin_out,   0);
        check("rst_err",       err,       0);
        reset_n = 1'b1;
        step();

`ifdef SEG_STABLE_FILTER_EN
        // ones 7,7 then 1,1,1: only the fifth sample completes the ones digit
        put(1'b0, 7'h70); put(1'b0, 7'h70);
        put(1'b0, 7'h30); put(1'b0, 7'h30); put(1'b0, 7'h30);
        put(1'b1, 7'h7E); put(1'b1, 7'h7E);
        @(negedge clk);
        check("flt_not_yet_valid", out_valid, 0);
        step();
        put(1'b1, 7'h7E);
        @(negedge clk);
        check("flt_out_valid", out_valid, 1);
        check("flt_bin_1",     bin_out,   1);
        step();
        check("flt_after_hs",  out_valid, 0);

        // blank held four times reports a single error
        put(1'b0, 7'h00); put(1'b0, 7'h00);
        @(negedge clk);
        check("flt_no_err_early", err, 0);
        step();
        put(1'b0, 7'h00);
        @(negedge clk);
        check("flt_err_pulse", err, 1);
        step();
        put(1'b0, 7'h00);
        @(negedge clk);
        check("flt_err_once", err, 0);
        step();
`else
        // 59 with immediate consumer
        put(1'b0, 7'h7B); put(1'b1, 7'h5B);
        @(negedge clk);
        check("t1_out_valid", out_valid, 1);
        check("t1_bin_59",    bin_out,   59);
        check("t1_err",       err,       0);
        check("t1_seg_ready", seg_ready, 0);
        step();
        @(negedge clk);
        check("t1_valid_1cyc", out_valid, 0);
        check("t1_ready_back", seg_ready, 1);
        step();

        // 10 held under backpressure
        out_ready = 1'b0;
        put(1'b1, 7'h30); put(1'b0, 7'h7E);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_seg_ready", seg_ready, 0);
            check("t2_out_valid", out_valid, 1);
            check("t2_bin_10",    bin_out,   10);
            step();
        end
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("t2_empty_valid", out_valid, 0);
        check("t2_empty_ready", seg_ready, 1);
        step();

        // ones overwrite: 4 replaced by 6, tens 2
        put(1'b0, 7'h33); put(1'b0, 7'h5F); put(1'b1, 7'h6D);
        @(negedge clk);
        check("t3_out_valid", out_valid, 1);
        check("t3_bin_26",    bin_out,   26);
        step();

        // illegal blank aborts the pair
        put(1'b1, 7'h7F); put(1'b0, 7'h00);
        @(negedge clk);
        check("t4_err_pulse", err,       1);
        check("t4_no_valid",  out_valid, 0);
        step();
        @(negedge clk);
        check("t4_err_once",  err,       0);
        step();
        put(1'b1, 7'h79); put(1'b0, 7'h79);
        @(negedge clk);
        check("t4_out_valid", out_valid, 1);
        check("t4_bin_33",    bin_out,   33);
        step();

        // reset in HAVE_TENS (tens = 6)
        put(1'b1, 7'h5F);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t5a_rst_bin",   bin_out,   0);
        check("t5a_rst_ready", seg_ready, 1);
        check("t5a_rst_valid", out_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        put(1'b0, 7'h30);
        @(negedge clk);
        check("t5a_partial_gone", out_valid, 0);
        step();
        put(1'b1, 7'h7B);
        @(negedge clk);
        check("t5a_bin_91", bin_out, 91);
        step();

        // reset in FULL (85 waiting)
        out_ready = 1'b0;
        put(1'b0, 7'h5B); put(1'b1, 7'h7F);
        @(negedge clk);
        check("t5b_full_bin_85", bin_out, 85);
        reset_n = 1'b0;
        #1;
        check("t5b_rst_valid", out_valid, 0);
        check("t5b_rst_ready", seg_ready, 1);
        check("t5b_rst_bin",   bin_out,   0);
        check("t5b_rst_err",   err,       0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        put(1'b0, 7'h70); put(1'b1, 7'h33);
        @(negedge clk);
        check("t5b_out_valid", out_valid, 1);
        check("t5b_bin_47",    bin_out,   47);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
